// File: rtl/sm_sched_pkg.sv
// Shared types and helpers for the MMC arm insertion scheduler.
// Holds the controller state encoding, the insertion-count width helper
// and a voltage extractor for the packed capacitor-voltage bus.
package sm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_FINISH = 2'd2
  } sm_state_e;

  // Upper bounds for the generic voltage extractor below.
  localparam int SM_BUS_MAX = 512;
  localparam int SM_V_MAX   = 32;

  // Width needed to hold an insertion count from 0 to n inclusive.
  function automatic int sm_cw(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int SM_N_DEF  = 5;
  localparam int SM_CW_DEF = sm_cw(SM_N_DEF);

  // Voltage of submodule idx from a zero-extended packed bus of vw-bit fields.
  function automatic logic [SM_V_MAX-1:0] sm_get_v(
    input logic [SM_BUS_MAX-1:0] bus,
    input int unsigned           idx,
    input int unsigned           vw
  );
    logic [SM_BUS_MAX-1:0] sh;
    sh = bus >> (idx * vw);
    return sh[SM_V_MAX-1:0] & ((SM_V_MAX'(1) << vw) - SM_V_MAX'(1));
  endfunction

endpackage

// File: rtl/sm_extreme_finder.sv
// Combinational argmin/argmax over N_SM unsigned voltages.
// Only entries with their valid bit set compete; ties resolve to the
// lowest index in both directions. found is low when no entry is valid.
module sm_extreme_finder
  import sm_sched_pkg::*;
#(
  parameter int N_SM = 5,
  parameter int VW   = 12,
  parameter int IW   = (N_SM > 1) ? $clog2(N_SM) : 1
) (
  input  logic [N_SM*VW-1:0] v_flat,
  input  logic [N_SM-1:0]    valid,
  input  logic               find_max,
  output logic [IW-1:0]      idx,
  output logic               found
);

  logic [SM_BUS_MAX-1:0] bus_ext;
  logic [VW-1:0]         v_arr [N_SM];
  logic [VW-1:0]         best;

  assign bus_ext = SM_BUS_MAX'(v_flat);

  for (genvar gi = 0; gi < N_SM; gi++) begin : g_unpack
    assign v_arr[gi] = VW'(sm_get_v(bus_ext, gi, VW));
  end

  // Linear scan; strict compare keeps the earliest index on ties.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '0;
    for (int i = 0; i < N_SM; i++) begin
      if (valid[i]) begin
        if (!found || (find_max ? (v_arr[i] > best) : (v_arr[i] < best))) begin
          found = 1'b1;
          best  = v_arr[i];
          idx   = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sm_insertion_scheduler.sv
// Voltage-balancing insertion scheduler for one MMC arm.
// On start, latches the voltages, direction and count, then picks one
// submodule per cycle (lowest voltage when charging, highest when
// discharging) and publishes the finished mask in a single update.
// Optional build macro SM_SCHED_CNT_EN adds a 16-bit wrapping counter of
// published schedules on output sched_cnt.
module sm_insertion_scheduler
  import sm_sched_pkg::*;
#(
  parameter int N_SM = 5,
  parameter int VW   = 12,
  parameter int CW   = sm_cw(N_SM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CW-1:0]      n_on,
  input  logic               chg,
  input  logic [N_SM*VW-1:0] v_cap,
  output logic               busy,
  output logic               done,
  output logic [N_SM-1:0]    gate_mask,
  output logic               mask_valid
`ifdef SM_SCHED_CNT_EN
  ,
  output logic [15:0]        sched_cnt
`endif
);

  localparam int IW = (N_SM > 1) ? $clog2(N_SM) : 1;

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SELECT = ST_SELECT;
  localparam logic [1:0] S_FINISH = ST_FINISH;

  localparam logic [CW-1:0] N_SAT = CW'(N_SM);

  logic [1:0]         state_reg;
  logic [CW-1:0]      rem_reg;
  logic [N_SM-1:0]    sel_reg;
  logic [N_SM*VW-1:0] v_lat_reg;
  logic               chg_reg;
  logic [N_SM-1:0]    gate_mask_reg;
  logic               done_reg;
  logic               mask_valid_reg;

  logic [IW-1:0]      f_idx;
  logic               f_found;
`ifdef SM_SCHED_CNT_EN
  logic [15:0]        cnt_reg;
`endif

  // Candidates are every submodule not yet chosen in this schedule.
  sm_extreme_finder #(
    .N_SM (N_SM),
    .VW   (VW),
    .IW   (IW)
  ) u_finder (
    .v_flat   (v_lat_reg),
    .valid    (~sel_reg),
    .find_max (~chg_reg),
    .idx      (f_idx),
    .found    (f_found)
  );

  // Controller: latch on start, select one entry per cycle, publish, return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      rem_reg        <= '0;
      sel_reg        <= '0;
      v_lat_reg      <= '0;
      chg_reg        <= 1'b0;
      gate_mask_reg  <= '0;
      done_reg       <= 1'b0;
      mask_valid_reg <= 1'b0;
`ifdef SM_SCHED_CNT_EN
      cnt_reg        <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            v_lat_reg <= v_cap;
            chg_reg   <= chg;
            rem_reg   <= (n_on > N_SAT) ? N_SAT : n_on;
            sel_reg   <= '0;
            state_reg <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (rem_reg != '0) begin
            if (f_found) begin
              sel_reg[f_idx] <= 1'b1;
            end
            rem_reg <= rem_reg - CW'(1);
          end else begin
            gate_mask_reg  <= sel_reg;
            done_reg       <= 1'b1;
            mask_valid_reg <= 1'b1;
            state_reg      <= S_FINISH;
`ifdef SM_SCHED_CNT_EN
            cnt_reg        <= cnt_reg + 16'd1;
`endif
          end
        end
        S_FINISH: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_reg != S_IDLE);
  assign done       = done_reg;
  assign gate_mask  = gate_mask_reg;
  assign mask_valid = mask_valid_reg;
`ifdef SM_SCHED_CNT_EN
  assign sched_cnt  = cnt_reg;
`endif

endmodule
